// File: rtl/core_pkg.sv
// Shared constants for the pipeline boundary registers of the core.
// Control fields are packed at the LSB end of every boundary bundle, so the
// kill masks cover the low bits only.
package core_pkg;

    // Bundle widths for each pipeline boundary
    localparam int unsigned FD_W = 64;   // pc + instruction
    localparam int unsigned DE_W = 144;  // pc, rs1/rs2 values, imm, decoded ctrl
    localparam int unsigned EM_W = 112;  // alu result, store data, rd, mem ctrl
    localparam int unsigned MW_W = 72;   // writeback value, rd, wb ctrl

    // Bits cleared on flush, bubble and reset for each boundary
    localparam logic [FD_W-1:0] FD_CTRL_MASK = 64'h0000_0000_0000_0001;
    localparam logic [DE_W-1:0] DE_CTRL_MASK = 144'h0000_0000_0000_0000_0000_0000_0000_0000_0FFF;
    localparam logic [EM_W-1:0] EM_CTRL_MASK = 112'h0000_0000_0000_0000_0000_0000_003F;
    localparam logic [MW_W-1:0] MW_CTRL_MASK = 72'h00_0000_0000_0000_0003;

    // Default width of the hazard performance counters
    localparam int unsigned DEF_CNT_W = 16;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear and a multi-bit increment.
module sat_counter #(
    parameter int unsigned CNT_W = 16,
    parameter int unsigned INC_W = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic [INC_W-1:0] inc,
    output logic [CNT_W-1:0] count
);

    // One spare bit above the wider operand so the overflow is visible
    localparam int unsigned SUM_W = ((CNT_W > INC_W) ? CNT_W : INC_W) + 1;
    localparam logic [SUM_W-1:0] MAX = SUM_W'({CNT_W{1'b1}});

    logic [SUM_W-1:0] sum;

    // Widened sum of the current count and the increment
    always_comb begin
        sum = SUM_W'(count) + SUM_W'(inc);
    end

    // Clear wins over increment; the count sticks at all ones once reached
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (sum > MAX) begin
            count <= '1;
        end else begin
            count <= sum[CNT_W-1:0];
        end
    end

endmodule

// File: rtl/pipeline_stage_reg.sv
// Parametrised pipeline register chain with per-stage stall, flush and
// automatic bubble insertion, plus stall/bubble performance counters.
module pipeline_stage_reg
    import core_pkg::*;
#(
    parameter int unsigned      WIDTH     = 32,
    parameter int unsigned      DEPTH     = 1,
    parameter logic [WIDTH-1:0] CTRL_MASK = '1,
    parameter int unsigned      CNT_W     = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    input  logic [DEPTH-1:0] stall,
    input  logic [DEPTH-1:0] flush,
    input  logic             cnt_clr,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic [DEPTH-1:0] stage_valid,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] bubble_cnt
);

    // Enough bits to hold a bubble count of up to DEPTH per cycle
    localparam int unsigned INC_W = $clog2(DEPTH + 1);

    logic [DEPTH-1:0] valid;
    logic [WIDTH-1:0] data [DEPTH];
    logic [DEPTH-1:0] bubble_hit;
    logic [INC_W-1:0] bubble_inc;
    logic             stall_hit;

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        logic             src_valid;
        logic [WIDTH-1:0] src_data;
        logic             bubble;
        logic             v_q;
        logic [WIDTH-1:0] d_q;

        if (i == 0) begin : g_head
            assign src_valid = in_valid;
            assign src_data  = in_data;
            assign bubble    = 1'b0;
        end else begin : g_body
            assign src_valid = valid[i-1];
            assign src_data  = data[i-1];
            assign bubble    = stall[i-1];
        end

        // A bubble is only counted when it actually displaces a valid entry,
        // i.e. neither flush nor a local stall took priority this cycle
        assign bubble_hit[i] = bubble & ~flush[i] & ~stall[i] & src_valid;

        // Stage register: flush > stall > bubble > load
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                v_q <= 1'b0;
                d_q <= '0;
            end else if (flush[i]) begin
                v_q <= 1'b0;
                d_q <= src_data & ~CTRL_MASK;
            end else if (stall[i]) begin
                v_q <= v_q;
                d_q <= d_q;
            end else if (bubble) begin
                v_q <= 1'b0;
                d_q <= src_data & ~CTRL_MASK;
            end else begin
                v_q <= src_valid;
                d_q <= src_data;
            end
        end

        assign valid[i] = v_q;
        assign data[i]  = d_q;
    end

    // Number of stages inserting a bubble over a valid entry this cycle
    always_comb begin
        bubble_inc = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            bubble_inc = bubble_inc + INC_W'(bubble_hit[k]);
        end
    end

    assign stall_hit = stall[0] & in_valid;

    sat_counter #(
        .CNT_W (CNT_W),
        .INC_W (1)
    ) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (cnt_clr),
        .inc   (stall_hit),
        .count (stall_cnt)
    );

    sat_counter #(
        .CNT_W (CNT_W),
        .INC_W (INC_W)
    ) u_bubble_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (cnt_clr),
        .inc   (bubble_inc),
        .count (bubble_cnt)
    );

    assign out_valid   = valid[DEPTH-1];
    assign out_data    = data[DEPTH-1];
    assign stage_valid = valid;

endmodule

// File: tb/tb_pipeline_stage_reg.sv
// Directed self-checking bench for pipeline_stage_reg across four configurations.
module tb_pipeline_stage_reg;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int unsigned pass_cnt = 0;
    int unsigned total_cnt = 0;

    // Instance A: DEPTH=3, full mask, 16-bit counters
    logic        a_in_valid = 1'b0;
    logic [31:0] a_in_data  = '0;
    logic [2:0]  a_stall    = '0;
    logic [2:0]  a_flush    = '0;
    logic        a_clr      = 1'b0;
    logic        a_out_valid;
    logic [31:0] a_out_data;
    logic [2:0]  a_stage_valid;
    logic [15:0] a_stall_cnt;
    logic [15:0] a_bubble_cnt;

    // Instance B: DEPTH=1, low-byte control mask, 4-bit counters
    logic        b_in_valid = 1'b0;
    logic [31:0] b_in_data  = '0;
    logic [0:0]  b_stall    = '0;
    logic [0:0]  b_flush    = '0;
    logic        b_clr      = 1'b0;
    logic        b_out_valid;
    logic [31:0] b_out_data;
    logic [0:0]  b_stage_valid;
    logic [3:0]  b_stall_cnt;
    logic [3:0]  b_bubble_cnt;

    // Instance C: DEPTH=4, full mask
    logic        c_in_valid = 1'b0;
    logic [31:0] c_in_data  = '0;
    logic [3:0]  c_stall    = '0;
    logic [3:0]  c_flush    = '0;
    logic        c_clr      = 1'b0;
    logic        c_out_valid;
    logic [31:0] c_out_data;
    logic [3:0]  c_stage_valid;
    logic [15:0] c_stall_cnt;
    logic [15:0] c_bubble_cnt;

    // Instance D: DEPTH=2, full mask
    logic        d_in_valid = 1'b0;
    logic [31:0] d_in_data  = '0;
    logic [1:0]  d_stall    = '0;
    logic [1:0]  d_flush    = '0;
    logic        d_clr      = 1'b0;
    logic        d_out_valid;
    logic [31:0] d_out_data;
    logic [1:0]  d_stage_valid;
    logic [15:0] d_stall_cnt;
    logic [15:0] d_bubble_cnt;

    pipeline_stage_reg #(.WIDTH(32), .DEPTH(3), .CTRL_MASK(32'hFFFF_FFFF), .CNT_W(16)) u_a (
        .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_data(a_in_data),
        .stall(a_stall), .flush(a_flush), .cnt_clr(a_clr),
        .out_valid(a_out_valid), .out_data(a_out_data), .stage_valid(a_stage_valid),
        .stall_cnt(a_stall_cnt), .bubble_cnt(a_bubble_cnt)
    );

    pipeline_stage_reg #(.WIDTH(32), .DEPTH(1), .CTRL_MASK(32'h0000_00FF), .CNT_W(4)) u_b (
        .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_data(b_in_data),
        .stall(b_stall), .flush(b_flush), .cnt_clr(b_clr),
        .out_valid(b_out_valid), .out_data(b_out_data), .stage_valid(b_stage_valid),
        .stall_cnt(b_stall_cnt), .bubble_cnt(b_bubble_cnt)
    );

    pipeline_stage_reg #(.WIDTH(32), .DEPTH(4), .CTRL_MASK(32'hFFFF_FFFF), .CNT_W(16)) u_c (
        .clk(clk), .rst(rst), .in_valid(c_in_valid), .in_data(c_in_data),
        .stall(c_stall), .flush(c_flush), .cnt_clr(c_clr),
        .out_valid(c_out_valid), .out_data(c_out_data), .stage_valid(c_stage_valid),
        .stall_cnt(c_stall_cnt), .bubble_cnt(c_bubble_cnt)
    );

    pipeline_stage_reg #(.WIDTH(32), .DEPTH(2), .CTRL_MASK(32'hFFFF_FFFF), .CNT_W(16)) u_d (
        .clk(clk), .rst(rst), .in_valid(d_in_valid), .in_data(d_in_data),
        .stall(d_stall), .flush(d_flush), .cnt_clr(d_clr),
        .out_valid(d_out_valid), .out_data(d_out_data), .stage_valid(d_stage_valid),
        .stall_cnt(d_stall_cnt), .bubble_cnt(d_bubble_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Upstream-monotonic: a stalled stage implies every earlier stage is stalled
    function automatic bit stall_legal2(input logic [1:0] s);
        return !(s[1] && !s[0]);
    endfunction

    initial begin
        logic [31:0] pt_data [3];
        int unsigned exp_sat;
        pt_data[0] = 32'hA;
        pt_data[1] = 32'hB;
        pt_data[2] = 32'hC;

        // Reset state
        tick();
        tick();
        check("rst_out_valid", 64'(a_out_valid), 64'(0));
        check("rst_out_data", 64'(a_out_data), 64'(0));
        check("rst_stall_cnt", 64'(a_stall_cnt), 64'(0));
        check("rst_bubble_cnt", 64'(a_bubble_cnt), 64'(0));
        rst = 1'b0;

        // Fill A, then reset mid-stream with no clock edge in between
        a_in_valid = 1'b1;
        a_in_data  = 32'h55;
        tick(); tick(); tick();
        check("pre_mid_rst_valid", 64'(a_out_valid), 64'(1));
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_out_valid", 64'(a_out_valid), 64'(0));
        check("mid_rst_out_data", 64'(a_out_data), 64'(0));
        check("mid_rst_stage_valid", 64'(a_stage_valid), 64'(0));
        a_in_valid = 1'b0;
        a_in_data  = '0;
        tick();
        rst = 1'b0;

        // Pass-through: A,B,C appear after three edges, one per cycle
        for (int k = 0; k < 6; k++) begin
            if (k < 3) begin
                a_in_valid = 1'b1;
                a_in_data  = pt_data[k];
            end else begin
                a_in_valid = 1'b0;
                a_in_data  = '0;
            end
            tick();
            if (k >= 2 && k <= 4) begin
                check($sformatf("pt_valid_%0d", k), 64'(a_out_valid), 64'(1));
                check($sformatf("pt_data_%0d", k), 64'(a_out_data), 64'(pt_data[k-2]));
            end
        end
        check("pt_drained", 64'(a_out_valid), 64'(0));

        // Stall stage 0 for two cycles with 0x11 inside
        a_in_valid = 1'b1;
        a_in_data  = 32'h11;
        tick();
        a_stall    = 3'b001;
        a_in_data  = 32'h22;
        tick();
        check("stall1_stage_valid", 64'(a_stage_valid), 64'(3'b001));
        tick();
        check("stall2_stage_valid", 64'(a_stage_valid), 64'(3'b001));
        check("stall2_bubble_cnt", 64'(a_bubble_cnt), 64'(2));
        check("stall2_stall_cnt", 64'(a_stall_cnt), 64'(2));
        check("stall2_out_valid", 64'(a_out_valid), 64'(0));
        check("stall2_out_data", 64'(a_out_data), 64'(0));
        a_stall    = 3'b000;
        a_in_valid = 1'b0;
        a_in_data  = '0;
        tick();
        tick();
        check("stall_rel_out_valid", 64'(a_out_valid), 64'(1));
        check("stall_rel_out_data", 64'(a_out_data), 64'(32'h11));
        check("stall_rel_stall_cnt", 64'(a_stall_cnt), 64'(2));

        // B: flush beats stall, unmasked bits still load
        b_in_valid = 1'b1;
        b_in_data  = 32'hDEAD_BEEF;
        tick();
        check("b_load_data", 64'(b_out_data), 64'(32'hDEAD_BEEF));
        b_flush   = 1'b1;
        b_stall   = 1'b1;
        b_in_data = 32'h1234_56FF;
        tick();
        check("flush_stall_valid", 64'(b_out_valid), 64'(0));
        check("flush_stall_data", 64'(b_out_data), 64'(32'h1234_5600));
        check("flush_stall_cnt", 64'(b_stall_cnt), 64'(1));

        // B: stall counter saturates at 15
        b_flush = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            exp_sat = (i + 1 > 15) ? 15 : i + 1;
            check($sformatf("sat_cnt_%0d", i), 64'(b_stall_cnt), 64'(exp_sat));
        end
        check("sat_hold_data", 64'(b_out_data), 64'(32'h1234_5600));
        check("depth1_bubble_cnt", 64'(b_bubble_cnt), 64'(0));
        b_clr = 1'b1;
        tick();
        check("clr_overrides_inc", 64'(b_stall_cnt), 64'(0));
        b_clr = 1'b0;
        tick();
        check("after_clr_inc", 64'(b_stall_cnt), 64'(1));

        // C: fill four stages with 1..4
        for (int k = 1; k <= 4; k++) begin
            c_in_valid = 1'b1;
            c_in_data  = 32'(k);
            tick();
        end
        check("c_full", 64'(c_stage_valid), 64'(4'hF));
        c_stall   = 4'b0011;
        c_in_data = 32'h5;
        tick();
        check("c_s0011_a_bubble", 64'(c_bubble_cnt), 64'(1));
        check("c_s0011_a_valid", 64'(c_stage_valid), 64'(4'b1011));
        check("c_s0011_a_out", 64'(c_out_data), 64'(2));
        tick();
        check("c_s0011_b_bubble", 64'(c_bubble_cnt), 64'(2));
        check("c_s0011_b_valid", 64'(c_stage_valid), 64'(4'b0011));
        c_stall = 4'b0001;
        tick();
        check("c_s0001_bubble", 64'(c_bubble_cnt), 64'(3));
        check("c_s0001_valid", 64'(c_stage_valid), 64'(4'b0101));
        check("c_stall_cnt", 64'(c_stall_cnt), 64'(3));
        c_stall    = 4'b0000;
        c_in_valid = 1'b0;
        tick();
        check("c_rel_out_valid", 64'(c_out_valid), 64'(1));
        check("c_rel_out_data", 64'(c_out_data), 64'(3));
        check("c_rel_valid", 64'(c_stage_valid), 64'(4'b1010));

        // D: non-monotonic stall overwrites upstream data
        d_in_valid = 1'b1;
        d_in_data  = 32'h100;
        tick();
        d_in_data = 32'h200;
        tick();
        d_stall   = 2'b10;
        d_in_data = 32'h300;
        if (!stall_legal2(d_stall))
            $display("note: non-monotonic stall vector %b applied to DEPTH=2 instance", d_stall);
        tick();
        check("illegal_hold_out", 64'(d_out_data), 64'(32'h100));
        check("illegal_stage_valid", 64'(d_stage_valid), 64'(2'b11));
        d_stall    = 2'b00;
        d_in_valid = 1'b0;
        tick();
        check("illegal_overwrite", 64'(d_out_data), 64'(32'h300));
        check("illegal_bubble_cnt", 64'(d_bubble_cnt), 64'(0));

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
